// File: rtl/monobit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monobit_pkg
// Description : Shared constants, stream-entry type and LFSR step function
//               for the monobit bit framer.
// Revision    : 1.0 - initial release
// ============================================================================
package monobit_pkg;

    localparam int          MONOBIT_BLOCK_LEN_DEF = 128;
    localparam logic [15:0] MONOBIT_LFSR_SEED     = 16'hACE1;

    // One buffered bit together with its block-position markers.
    typedef struct packed {
        logic data;
        logic first;
        logic last;
    } monobit_entry_t;

    localparam int MONOBIT_ENTRY_W = $bits(monobit_entry_t);

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; bit 0 is the output tap.
    function automatic logic [15:0] monobit_lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/monobit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : monobit_sync_fifo
// Description : Circular DEPTH x WIDTH synchronous FIFO. Pointers carry one
//               extra wrap bit so full and empty are told apart directly.
//               The head entry is presented combinationally and reads zero
//               while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module monobit_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty     = (r_wptr == r_rptr);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Storage array: written on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop in one cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/monobit_bit_framer.sv
`default_nettype none
// ============================================================================
// Module      : monobit_bit_framer
// Description : Synchronizes an external bit line and sample strobe, captures
//               one bit per strobe rising edge into a small FIFO and presents
//               it as a valid/ready stream with block first/last markers.
//               Optional macro MONOBIT_FRAMER_SELFTEST_EN adds a selftest port
//               and an internal LFSR bit source.
// Revision    : 1.0 - initial release
// ============================================================================
module monobit_bit_framer
    import monobit_pkg::*;
#(
    parameter int BLOCK_LEN  = MONOBIT_BLOCK_LEN_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             bit_in,
    input  logic             strobe_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_bit,
    output logic             m_first,
    output logic             m_last,
    output logic             overflow,
    output logic [CNT_W-1:0] blk_count
`ifdef MONOBIT_FRAMER_SELFTEST_EN
    ,
    input  logic             selftest
`endif
);

    localparam int POS_W = $clog2(BLOCK_LEN);
    localparam logic [POS_W-1:0] C_POS_LAST = POS_W'(BLOCK_LEN - 1);

    logic             r_bit_s1, r_bit_s2;
    logic             r_stb_s1, r_stb_s2, r_stb_prev;
    logic [POS_W-1:0] r_pos;
    logic             r_overflow;
    logic [CNT_W-1:0] r_blk_count;

    logic             w_rise;
    logic             w_src_evt;
    logic             w_src_bit;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_refuse;
    logic             w_first;
    logic             w_last;
    monobit_entry_t   w_wr_entry;
    monobit_entry_t   w_head;
    logic [MONOBIT_ENTRY_W-1:0] w_head_raw;

    // Two-flop synchronizers for both async inputs plus the strobe history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_s1   <= 1'b0;
            r_bit_s2   <= 1'b0;
            r_stb_s1   <= 1'b0;
            r_stb_s2   <= 1'b0;
            r_stb_prev <= 1'b0;
        end else begin
            r_bit_s1   <= bit_in;
            r_bit_s2   <= r_bit_s1;
            r_stb_s1   <= strobe_in;
            r_stb_s2   <= r_stb_s1;
            r_stb_prev <= r_stb_s2;
        end
    end

    assign w_rise = r_stb_s2 & ~r_stb_prev;

`ifdef MONOBIT_FRAMER_SELFTEST_EN
    logic [15:0] r_lfsr;

    // Selftest source: the LFSR steps each cycle unless its push is refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= MONOBIT_LFSR_SEED;
        end else if (selftest && !w_refuse) begin
            r_lfsr <= monobit_lfsr_next(r_lfsr);
        end
    end

    assign w_src_evt = selftest ? 1'b1      : w_rise;
    assign w_src_bit = selftest ? r_lfsr[0] : r_bit_s2;
`else
    assign w_src_evt = w_rise;
    assign w_src_bit = r_bit_s2;
`endif

    // Full is the pre-pop state, so a same-cycle pop never rescues a push.
    assign w_push   = w_src_evt & ena & ~w_full;
    assign w_refuse = w_src_evt & ena &  w_full;
    assign w_first  = (r_pos == '0);
    assign w_last   = (r_pos == C_POS_LAST);

    assign w_wr_entry.data  = w_src_bit;
    assign w_wr_entry.first = w_first;
    assign w_wr_entry.last  = w_last;

    // Block position, completed-block count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos       <= '0;
            r_blk_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_pos <= w_last ? '0 : r_pos + 1'b1;
                if (w_last) r_blk_count <= r_blk_count + 1'b1;
            end
            if (w_refuse) r_overflow <= 1'b1;
        end
    end

    monobit_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MONOBIT_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_wr_entry),
        .pop       (m_valid & m_ready),
        .pop_data  (w_head_raw),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head    = monobit_entry_t'(w_head_raw);
    assign m_valid   = ~w_empty;
    assign m_bit     = w_head.data;
    assign m_first   = w_head.first;
    assign m_last    = w_head.last;
    assign overflow  = r_overflow;
    assign blk_count = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_monobit_bit_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_monobit_bit_framer
// Description : Directed self-checking bench for monobit_bit_framer
//               (BLOCK_LEN=4, FIFO_DEPTH=4). Selftest section is compiled
//               when MONOBIT_FRAMER_SELFTEST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monobit_bit_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       bit_in = 1'b0;
    logic       strobe_in = 1'b0;
    logic       m_ready = 1'b0;
    logic       m_valid, m_bit, m_first, m_last, overflow;
    logic [7:0] blk_count;
`ifdef MONOBIT_FRAMER_SELFTEST_EN
    logic       selftest = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [2:0] q [$];   // collected {bit, first, last}

    monobit_bit_framer #(
        .BLOCK_LEN  (4),
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .bit_in    (bit_in),
        .strobe_in (strobe_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_bit     (m_bit),
        .m_first   (m_first),
        .m_last    (m_last),
        .overflow  (overflow),
        .blk_count (blk_count)
`ifdef MONOBIT_FRAMER_SELFTEST_EN
        ,
        .selftest  (selftest)
`endif
    );

    always #5 clk = ~clk;

    // Record every accepted stream transfer mid-cycle.
    always @(negedge clk) begin
        if (m_valid && m_ready) q.push_back({m_bit, m_first, m_last});
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic pulse(input logic b);
        bit_in    = b;
        strobe_in = 1'b1;
        tick(2);
        strobe_in = 1'b0;
        tick(3);
    endtask

    task automatic chk_entries(input string tag, input logic [2:0] exp [], input int n);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk($sformatf("%s_e%0d_bit", tag, i),   q[i][2], exp[i][2]);
            chk($sformatf("%s_e%0d_first", tag, i), q[i][1], exp[i][1]);
            chk($sformatf("%s_e%0d_last", tag, i),  q[i][0], exp[i][0]);
        end
    endtask

    initial begin
        logic [2:0] exp [];
        ena = 1'b1;
        tick(1);
        do_reset();

        // Reset state
        chk("rst_valid", m_valid, 0);
        chk("rst_bit", m_bit, 0);
        chk("rst_first", m_first, 0);
        chk("rst_last", m_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_blk", blk_count, 0);

        // Test 1: 5 bits, latency of first entry (m_ready held 0 for latency probe)
        bit_in = 1'b1; strobe_in = 1'b1;
        tick(1); chk("lat_e1", m_valid, 0);
        tick(1); chk("lat_e2", m_valid, 0);
        strobe_in = 1'b0;
        tick(1); chk("lat_e3", m_valid, 1);
        m_ready = 1'b1;
        tick(2);
        pulse(0); pulse(1); pulse(1); pulse(0);
        tick(3);
        exp = '{3'b110, 3'b000, 3'b100, 3'b101, 3'b010};
        chk_entries("t1", exp, 5);
        chk("t1_blk", blk_count, 1);

        // Test 2: 9 strobes, BLOCK_LEN=4 markers
        do_reset();
        pulse(1); pulse(1); pulse(0); pulse(0); pulse(1);
        pulse(0); pulse(1); pulse(0); pulse(1);
        tick(3);
        exp = '{3'b110, 3'b100, 3'b000, 3'b001, 3'b110,
                3'b000, 3'b100, 3'b001, 3'b110};
        chk_entries("t2", exp, 9);
        chk("t2_blk", blk_count, 2);

        // Test 3: back-pressure, overflow on the 5th strobe
        do_reset();
        m_ready = 1'b0;
        pulse(1); pulse(1); pulse(0); pulse(1);
        chk("t3_ovf4", overflow, 0);
        pulse(0);
        chk("t3_ovf5", overflow, 1);
        chk("t3_hold_valid", m_valid, 1);
        chk("t3_hold_bit", m_bit, 1);
        chk("t3_hold_first", m_first, 1);
        pulse(1);
        chk("t3_blk", blk_count, 1);
        m_ready = 1'b1;
        tick(8);
        exp = '{3'b110, 3'b100, 3'b000, 3'b101};
        chk_entries("t3", exp, 4);
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_empty", m_valid, 0);

        // Test 4: ena low ignores strobes, block not restarted
        do_reset();
        ena = 1'b0;
        pulse(1); pulse(0); pulse(1);
        chk("t4_valid_off", m_valid, 0);
        ena = 1'b1;
        pulse(1);
        tick(3);
        exp = '{3'b110};
        chk_entries("t4", exp, 1);
        chk("t4_ovf", overflow, 0);

        // Test 5: mid-operation reset discards queue and partial block
        do_reset();
        pulse(1); pulse(0); pulse(1); pulse(1);
        tick(2);
        m_ready = 1'b0;
        pulse(0); pulse(1);
        chk("t5_pre_valid", m_valid, 1);
        chk("t5_pre_blk", blk_count, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_valid", m_valid, 0);
        chk("t5_blk", blk_count, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_bit", m_bit, 0);
        q.delete();
        m_ready = 1'b1;
        pulse(0);
        tick(3);
        exp = '{3'b010};
        chk_entries("t5", exp, 1);

`ifdef MONOBIT_FRAMER_SELFTEST_EN
        // Test 6: LFSR source for 16 cycles
        begin
            logic [15:0] lf;
            logic        fb;
            do_reset();
            m_ready  = 1'b1;
            selftest = 1'b1;
            tick(16);
            selftest = 1'b0;
            tick(3);
            chk("t6_count", q.size(), 16);
            lf = 16'hACE1;
            for (int i = 0; i < 16 && i < q.size(); i++) begin
                chk($sformatf("t6_e%0d_bit", i), q[i][2], lf[0]);
                chk($sformatf("t6_e%0d_first", i), q[i][1], (i % 4) == 0);
                fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
                lf = {fb, lf[15:1]};
            end
            chk("t6_blk", blk_count, 4);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monobit_bit_framer.md
Name: monobit_bit_framer

Overview:
- Upstream feeder for the monobit frequency-test core.
- Takes an asynchronous external bit line plus a sample strobe and synchronizes both.
- Captures one bit per strobe rising edge and buffers it in a small FIFO.
- Presents the bits as a valid/ready stream tagged with block-start and block-end markers, so the downstream accumulator can compute one S_n per BLOCK_LEN-bit block.

Parameters:
- BLOCK_LEN, 128: bits per test block. Range 2..65535.
- FIFO_DEPTH, 4: entries in the bit buffer. Power of 2, at least 2.
- CNT_W, 8: width of the completed-block counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  capture enable
- bit_in  in  1  raw external random bit, asynchronous
- strobe_in  in  1  external sample strobe, asynchronous; a rising edge samples the bit
- m_valid  out  1  stream entry available
- m_ready  in  1  downstream accepts the entry
- m_bit  out  1  stream data bit
- m_first  out  1  entry is bit 0 of a block
- m_last  out  1  entry is bit BLOCK_LEN-1 of a block
- overflow  out  1  sticky flag: a strobe edge was lost because the FIFO was full
- blk_count  out  CNT_W  number of blocks fully pushed, wraps
- selftest  in  1  source select; present only with the optional feature

Behaviour:
- Reset values (rst high at a clk edge):
  - FIFO empty, so m_valid=0; m_bit, m_first and m_last read 0.
  - overflow=0, blk_count=0, bit position=0.
  - All synchronizer and edge-detect flops set to 0.
  - Applies mid-operation as well: pending entries are discarded and the partial block is abandoned.
- Synchronization:
  - bit_in and strobe_in each pass through a 2-flop synchronizer.
  - A third flop holds the previous synchronized strobe.
  - rise = sync_strobe & ~prev_strobe.
- Latency: m_valid goes high after the 3rd clk edge, counting the first edge that samples strobe_in high (FIFO previously empty). The captured bit is the synchronized bit_in aligned with that strobe.
- Push rule:
  - On rise & ena & ~full, write {bit, first, last} into the FIFO.
  - first = (pos==0); last = (pos==BLOCK_LEN-1).
  - pos increments on each push and wraps to 0 after BLOCK_LEN-1.
  - blk_count increments on each push with last=1, wrapping mod 2^CNT_W.
- Full:
  - full is evaluated before any same-cycle pop, so a push is refused even if a pop happens in that cycle.
  - A refused edge (rise & ena & full) sets overflow, which stays set until rst.
  - The bit is dropped and pos is unchanged.
- ena low:
  - Strobe edges are ignored; no overflow and pos is held.
  - FIFO continues to drain.
  - Rising ena does not restart the block.
- Pop rule:
  - m_valid = ~empty.
  - m_bit, m_first and m_last show the head entry combinationally.
  - m_valid & m_ready pops at the clk edge.
  - Push and pop in the same cycle when not full: both take effect and occupancy is unchanged.
- Stream stability: while m_valid=1 and m_ready=0, the head entry and m_valid stay stable.
- FIFO structure: circular, with read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection.

Optional Feature:
- MONOBIT_FRAMER_SELFTEST_EN defined:
  - Adds the selftest port and a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst.
  - While selftest=1, the synchronizer path is bypassed: the LFSR advances every cycle and its output bit is pushed every cycle under the same ena/full/overflow rules.
  - The LFSR holds its value when a push is refused.
- Undefined: no selftest port and no LFSR; behaviour is exactly as above.

Decomposition:
- Package monobit_pkg holds:
  - constant MONOBIT_BLOCK_LEN_DEF=128
  - constant MONOBIT_LFSR_SEED=16'hACE1
  - typedef monobit_entry_t {bit, first, last}
- One sub-module: monobit_sync_fifo, a parameterized DEPTH x WIDTH synchronous FIFO with push/pop/full/empty.
- The framer contains the synchronizers, edge detect, position/block counters and LFSR.

Test Plan:
- Reset then 5 strobe pulses with bits 1,0,1,1,0, m_ready=1 → 5 stream entries 1,0,1,1,0; first=1 on entry 0 only; m_valid rises 3 edges after the first strobe is sampled.
- BLOCK_LEN=4, 9 strobes with m_ready=1 → m_first on entries 0,4,8; m_last on entries 3,7; blk_count=2.
- m_ready=0 and 6 strobes with FIFO_DEPTH=4 → 4 entries held; overflow=1 after the 5th; after releasing m_ready, exactly the first 4 bits emerge.
- ena=0 during 3 strobes, then ena=1 and 1 strobe → only one entry, with first=1; overflow stays 0.
- Assert rst for 1 cycle with 2 entries queued and pos=2 → m_valid=0, blk_count=0, overflow=0; the next strobe gives first=1.
- SELFTEST_EN, selftest=1, m_ready=1 for 16 cycles → bits match the reference LFSR sequence from seed 16'hACE1.
